vtage_bank_upd: RTL and testbench
=================================

VTAGE_BANK_UPD -- requirements
Module: vtage_bank_upd

Interface
REQ-001 SHALL have parameter P_NUM_PRED, default 2, number of predict ports and feedback ports (1..4).
REQ-002 SHALL have parameter P_NUM_ENTRIES, default 256, table depth (power of 2); LIW = $clog2(P_NUM_ENTRIES).
REQ-003 SHALL have parameter P_VALUE_WIDTH, default 32, predicted value width.
REQ-004 SHALL have parameter P_CONF_WIDTH, default 3, confidence counter width.
REQ-005 SHALL have parameter P_TAG_WIDTH, default 8, tag width.
REQ-006 SHALL have parameter P_U_WIDTH, default 2, usefulness counter width.
REQ-007 SHALL have parameter P_TAGGED, default 1; 0 = untagged base (LVP) bank, 1 = tagged bank.
REQ-008 SHALL have port clk_i, input, 1, the single clock; all logic on posedge.
REQ-009 SHALL have port rst_i, input, 1, synchronous active-low reset.
REQ-010 SHALL have port init_done_o, output, 1, table initialised and bank accepting traffic.
REQ-011 SHALL have ports fw_valid_i / fw_index_i / fw_tag_i, inputs, [N] / [N][LIW] / [N][P_TAG_WIDTH], predict requests.
REQ-012 SHALL have ports pred_valid_o, pred_hit_o, pred_value_o, pred_conf_o, pred_tag_o, pred_useful_o, outputs, [N] x {1, 1, P_VALUE_WIDTH, P_CONF_WIDTH, P_TAG_WIDTH, P_U_WIDTH}, prediction results.
REQ-013 SHALL have ports fb_valid_i, fb_index_i, fb_tag_i, fb_actual_i, fb_hit_i, fb_alloc_i, inputs, [N] x {1, LIW, P_TAG_WIDTH, P_VALUE_WIDTH, 1, 1}, feedback/update requests.
REQ-014 SHALL have port fb_collision_cnt_o, output, 16, saturating count of dropped feedback writes.

Function
REQ-015 Entry SHALL be {value, conf, tag, u}, stored in a flop array of P_NUM_ENTRIES entries.
REQ-016 FSM SHALL have states INIT and RUN; INIT writes all-zero to entry init_ptr and increments init_ptr each cycle; INIT -> RUN after writing entry P_NUM_ENTRIES-1.
REQ-017 init_done_o SHALL be 1 only in RUN; in INIT, fw_valid_i and fb_valid_i SHALL be ignored and pred_valid_o SHALL be 0.
REQ-018 Predict latency SHALL be 1 cycle: pred_valid_o[i] = registered (fw_valid_i[i] & RUN); pred_* SHALL reflect entry fw_index_i[i] as it was at the sampling edge, i.e. pre-update on same-cycle write.
REQ-019 pred_hit_o[i] SHALL be (registered fw_tag_i[i] == entry.tag) when P_TAGGED=1; constant 1 when P_TAGGED=0; pred_tag_o and pred_useful_o SHALL be 0 when P_TAGGED=0.
REQ-020 Feedback SHALL be read-modify-write in one cycle using current table contents; write takes effect at the next edge.
REQ-021 Hit update (fb_hit_i=1, or P_TAGGED=0), actual == value: conf +1 saturating at all-ones; u +1 saturating (tagged only).
REQ-022 Hit update, actual != value: if conf != 0, conf <= 0 and value unchanged; if conf == 0, value <= actual; u <= 0.
REQ-023 Miss (fb_hit_i=0, fb_alloc_i=1, P_TAGGED=1): if u == 0, entry <= {actual, 0, fb_tag_i, 0}; else u -1, other fields unchanged.
REQ-024 Miss without fb_alloc_i SHALL not modify the table.
REQ-025 Two or more valid feedback ports with the same fb_index_i SHALL be resolved so that the highest-numbered port writes; each lower port dropped SHALL increment fb_collision_cnt_o by 1, saturating at 16'hFFFF.
REQ-026 Feedback at different indices in the same cycle SHALL all be applied.

Reset
REQ-027 rst_i=0 at a posedge SHALL force state INIT, init_ptr 0, pred_valid_o 0, fb_collision_cnt_o 0, init_done_o 0, regardless of the current state, including mid-sweep.
REQ-028 Other pred_* outputs SHALL be 0 during reset and INIT; table contents are defined only after the sweep completes (all zero).

Verification
REQ-029 Reset release, P_NUM_ENTRIES=256 -> init_done_o rises exactly 256 cycles after the first cycle with rst_i=1; every read returns 0 with conf 0.
REQ-030 Reset asserted at init_ptr=100 -> sweep restarts from 0; init_done_o rises 256 cycles after rst_i deasserts.
REQ-031 Index 5, tag 0x3C, fb_alloc with u=0, actual 0x1234 -> next-cycle predict of index 5 with tag 0x3C gives hit=1, value 0x1234, conf 0; tag 0x3D gives hit=0.
REQ-032 Eight matching hit feedbacks on index 5, P_CONF_WIDTH=3 -> conf 7 (saturated after 7); one mismatch -> conf 0, value kept; second mismatch actual 0xBEEF -> value 0xBEEF.
REQ-033 Ports 0 and 1 give feedback to index 9 in the same cycle -> only port 1's update is visible; fb_collision_cnt_o increments 0 -> 1.
REQ-034 Predict and feedback to index 9 in the same cycle -> prediction shows pre-update entry; predict on the next cycle shows the updated entry.

Source files
------------

// File: rtl/vtage_bank_upd_if.sv
// rtl/vtage_bank_upd_if.sv - predict and feedback port bundle for one VTAGE bank
interface vtage_bank_upd_if #(
    parameter int NP  = 2,
    parameter int LIW = 8,
    parameter int VW  = 32,
    parameter int CW  = 3,
    parameter int TW  = 8,
    parameter int UW  = 2
);
    logic [NP-1:0]          fw_valid_i;
    logic [NP-1:0][LIW-1:0] fw_index_i;
    logic [NP-1:0][TW-1:0]  fw_tag_i;

    logic [NP-1:0]          pred_valid_o;
    logic [NP-1:0]          pred_hit_o;
    logic [NP-1:0][VW-1:0]  pred_value_o;
    logic [NP-1:0][CW-1:0]  pred_conf_o;
    logic [NP-1:0][TW-1:0]  pred_tag_o;
    logic [NP-1:0][UW-1:0]  pred_useful_o;

    logic [NP-1:0]          fb_valid_i;
    logic [NP-1:0][LIW-1:0] fb_index_i;
    logic [NP-1:0][TW-1:0]  fb_tag_i;
    logic [NP-1:0][VW-1:0]  fb_actual_i;
    logic [NP-1:0]          fb_hit_i;
    logic [NP-1:0]          fb_alloc_i;

    modport master (
        output fw_valid_i, fw_index_i, fw_tag_i,
        output fb_valid_i, fb_index_i, fb_tag_i, fb_actual_i, fb_hit_i, fb_alloc_i,
        input  pred_valid_o, pred_hit_o, pred_value_o, pred_conf_o, pred_tag_o, pred_useful_o
    );

    modport slave (
        input  fw_valid_i, fw_index_i, fw_tag_i,
        input  fb_valid_i, fb_index_i, fb_tag_i, fb_actual_i, fb_hit_i, fb_alloc_i,
        output pred_valid_o, pred_hit_o, pred_value_o, pred_conf_o, pred_tag_o, pred_useful_o
    );
endinterface

// File: rtl/vtage_bank_upd.sv
// rtl/vtage_bank_upd.sv - VTAGE value-prediction bank with init sweep, predict and update
module vtage_bank_upd #(
    parameter int P_NUM_PRED    = 2,
    parameter int P_NUM_ENTRIES = 256,
    parameter int P_VALUE_WIDTH = 32,
    parameter int P_CONF_WIDTH  = 3,
    parameter int P_TAG_WIDTH   = 8,
    parameter int P_U_WIDTH     = 2,
    parameter int P_TAGGED      = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        init_done_o,
    output logic [15:0] fb_collision_cnt_o,
    vtage_bank_upd_if.slave bus
);
    localparam int LIW = $clog2(P_NUM_ENTRIES);
    localparam int NP  = P_NUM_PRED;
    localparam int VW  = P_VALUE_WIDTH;
    localparam int CW  = P_CONF_WIDTH;
    localparam int TW  = P_TAG_WIDTH;
    localparam int UW  = P_U_WIDTH;

    typedef enum logic {ST_INIT, ST_RUN} state_e;

    state_e         state_q, state_d;
    logic [LIW-1:0] init_ptr_q, init_ptr_d;
    logic [15:0]    coll_cnt_q, coll_cnt_d;
    logic           run;

    logic [VW-1:0] value_q [P_NUM_ENTRIES];
    logic [CW-1:0] conf_q  [P_NUM_ENTRIES];
    logic [TW-1:0] tag_q   [P_NUM_ENTRIES];
    logic [UW-1:0] u_q     [P_NUM_ENTRIES];

    logic [NP-1:0]          pred_valid_q, pred_valid_d;
    logic [NP-1:0]          pred_hit_q, pred_hit_d;
    logic [NP-1:0][VW-1:0]  pred_value_q, pred_value_d;
    logic [NP-1:0][CW-1:0]  pred_conf_q, pred_conf_d;
    logic [NP-1:0][TW-1:0]  pred_tag_q, pred_tag_d;
    logic [NP-1:0][UW-1:0]  pred_useful_q, pred_useful_d;

    logic [NP-1:0]          wr_en;
    logic [NP-1:0][VW-1:0]  wr_value;
    logic [NP-1:0][CW-1:0]  wr_conf;
    logic [NP-1:0][TW-1:0]  wr_tag;
    logic [NP-1:0][UW-1:0]  wr_u;
    logic [NP-1:0]          dropped;
    logic [2:0]             n_drop;
    logic [16:0]            coll_sum;

    assign run = (state_q == ST_RUN);

    always_comb begin
        state_d    = state_q;
        init_ptr_d = init_ptr_q;
        case (state_q)
            ST_INIT: begin
                init_ptr_d = init_ptr_q + LIW'(1);
                if (init_ptr_q == LIW'(P_NUM_ENTRIES - 1)) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // A lower port loses to any higher valid port aimed at the same entry.
    always_comb begin
        dropped = '0;
        n_drop  = '0;
        for (int p = 0; p < NP; p++) begin
            for (int q = 0; q < NP; q++) begin
                if (q > p && bus.fb_valid_i[p] && bus.fb_valid_i[q] &&
                    bus.fb_index_i[p] == bus.fb_index_i[q]) begin
                    dropped[p] = 1'b1;
                end
            end
            if (run && dropped[p]) begin
                n_drop = n_drop + 3'd1;
            end
        end
        coll_sum   = 17'(coll_cnt_q) + 17'(n_drop);
        coll_cnt_d = coll_sum[16] ? 16'hFFFF : coll_sum[15:0];
    end

    always_comb begin
        wr_en    = '0;
        wr_value = '0;
        wr_conf  = '0;
        wr_tag   = '0;
        wr_u     = '0;
        for (int p = 0; p < NP; p++) begin
            wr_value[p] = value_q[bus.fb_index_i[p]];
            wr_conf[p]  = conf_q[bus.fb_index_i[p]];
            wr_tag[p]   = tag_q[bus.fb_index_i[p]];
            wr_u[p]     = u_q[bus.fb_index_i[p]];
            if (P_TAGGED == 0 || bus.fb_hit_i[p]) begin
                wr_en[p] = 1'b1;
                if (bus.fb_actual_i[p] == wr_value[p]) begin
                    if (wr_conf[p] != '1) wr_conf[p] = wr_conf[p] + CW'(1);
                    if (wr_u[p] != '1)    wr_u[p]    = wr_u[p] + UW'(1);
                end else begin
                    if (wr_conf[p] != '0) wr_conf[p]  = '0;
                    else                  wr_value[p] = bus.fb_actual_i[p];
                    wr_u[p] = '0;
                end
            end else if (bus.fb_alloc_i[p]) begin
                wr_en[p] = 1'b1;
                if (wr_u[p] == '0) begin
                    wr_value[p] = bus.fb_actual_i[p];
                    wr_conf[p]  = '0;
                    wr_tag[p]   = bus.fb_tag_i[p];
                end else begin
                    wr_u[p] = wr_u[p] - UW'(1);
                end
            end
            if (P_TAGGED == 0) begin
                wr_tag[p] = '0;
                wr_u[p]   = '0;
            end
            wr_en[p] = wr_en[p] & run & bus.fb_valid_i[p] & ~dropped[p];
        end
    end

    always_comb begin
        pred_valid_d  = '0;
        pred_hit_d    = '0;
        pred_value_d  = '0;
        pred_conf_d   = '0;
        pred_tag_d    = '0;
        pred_useful_d = '0;
        for (int i = 0; i < NP; i++) begin
            if (run && bus.fw_valid_i[i]) begin
                pred_valid_d[i] = 1'b1;
                pred_value_d[i] = value_q[bus.fw_index_i[i]];
                pred_conf_d[i]  = conf_q[bus.fw_index_i[i]];
                if (P_TAGGED != 0) begin
                    pred_tag_d[i]    = tag_q[bus.fw_index_i[i]];
                    pred_useful_d[i] = u_q[bus.fw_index_i[i]];
                    pred_hit_d[i]    = (bus.fw_tag_i[i] == tag_q[bus.fw_index_i[i]]);
                end else begin
                    pred_hit_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q       <= ST_INIT;
            init_ptr_q    <= '0;
            coll_cnt_q    <= '0;
            pred_valid_q  <= '0;
            pred_hit_q    <= '0;
            pred_value_q  <= '0;
            pred_conf_q   <= '0;
            pred_tag_q    <= '0;
            pred_useful_q <= '0;
        end else begin
            state_q       <= state_d;
            init_ptr_q    <= init_ptr_d;
            coll_cnt_q    <= coll_cnt_d;
            pred_valid_q  <= pred_valid_d;
            pred_hit_q    <= pred_hit_d;
            pred_value_q  <= pred_value_d;
            pred_conf_q   <= pred_conf_d;
            pred_tag_q    <= pred_tag_d;
            pred_useful_q <= pred_useful_d;
        end
    end

    // Table carries no reset; the INIT sweep is what defines its contents.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            if (state_q == ST_INIT) begin
                value_q[init_ptr_q] <= '0;
                conf_q[init_ptr_q]  <= '0;
                tag_q[init_ptr_q]   <= '0;
                u_q[init_ptr_q]     <= '0;
            end else begin
                for (int p = 0; p < NP; p++) begin
                    if (wr_en[p]) begin
                        value_q[bus.fb_index_i[p]] <= wr_value[p];
                        conf_q[bus.fb_index_i[p]]  <= wr_conf[p];
                        tag_q[bus.fb_index_i[p]]   <= wr_tag[p];
                        u_q[bus.fb_index_i[p]]     <= wr_u[p];
                    end
                end
            end
        end
    end

    assign init_done_o        = run;
    assign fb_collision_cnt_o = coll_cnt_q;
    assign bus.pred_valid_o   = pred_valid_q;
    assign bus.pred_hit_o     = pred_hit_q;
    assign bus.pred_value_o   = pred_value_q;
    assign bus.pred_conf_o    = pred_conf_q;
    assign bus.pred_tag_o     = pred_tag_q;
    assign bus.pred_useful_o  = pred_useful_q;
endmodule

// File: tb/tb_vtage_bank_upd.sv
// tb/tb_vtage_bank_upd.sv - scoreboard bench for vtage_bank_upd against an entry-level model
module tb_vtage_bank_upd;
    localparam int NP = 2;
    localparam int NE = 256;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        init_done_o;
    logic [15:0] fb_collision_cnt_o;

    vtage_bank_upd_if #(.NP(NP), .LIW(8), .VW(32), .CW(3), .TW(8), .UW(2)) bus ();

    vtage_bank_upd #(
        .P_NUM_PRED(NP), .P_NUM_ENTRIES(NE), .P_VALUE_WIDTH(32),
        .P_CONF_WIDTH(3), .P_TAG_WIDTH(8), .P_U_WIDTH(2), .P_TAGGED(1)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .init_done_o(init_done_o),
        .fb_collision_cnt_o(fb_collision_cnt_o),
        .bus(bus)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] v;
        logic [2:0]  c;
        logic [7:0]  t;
        logic [1:0]  u;
    } ent_t;

    typedef struct {
        int          port;
        logic [31:0] v;
        logic [2:0]  c;
        logic [7:0]  t;
        logic [1:0]  u;
        logic        h;
    } exp_t;

    ent_t mdl [NE];
    exp_t sbq [$];
    int   total = 0;
    int   bad = 0;
    int   exp_cnt = 0;
    bit   model_run = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < NE; i++) mdl[i] = '{32'h0, 3'h0, 8'h0, 2'h0};
    endtask

    task automatic idle();
        bus.fw_valid_i  = '0;
        bus.fw_index_i  = '0;
        bus.fw_tag_i    = '0;
        bus.fb_valid_i  = '0;
        bus.fb_index_i  = '0;
        bus.fb_tag_i    = '0;
        bus.fb_actual_i = '0;
        bus.fb_hit_i    = '0;
        bus.fb_alloc_i  = '0;
    endtask

    // Queue expected predictions, advance the model by one cycle of feedback, then clock.
    task automatic step();
        ent_t nm [NE];
        if (model_run) begin
            for (int i = 0; i < NP; i++) begin
                if (bus.fw_valid_i[i]) begin
                    ent_t e;
                    e = mdl[bus.fw_index_i[i]];
                    sbq.push_back('{i, e.v, e.c, e.t, e.u, e.t == bus.fw_tag_i[i]});
                end
            end
            nm = mdl;
            for (int p = 0; p < NP; p++) begin
                bit lost;
                ent_t e;
                logic [31:0] a;
                if (!bus.fb_valid_i[p]) continue;
                lost = 0;
                for (int q = p + 1; q < NP; q++)
                    if (bus.fb_valid_i[q] && bus.fb_index_i[q] == bus.fb_index_i[p]) lost = 1;
                if (lost) begin
                    if (exp_cnt < 65535) exp_cnt++;
                    continue;
                end
                e = mdl[bus.fb_index_i[p]];
                a = bus.fb_actual_i[p];
                if (bus.fb_hit_i[p]) begin
                    if (a == e.v) begin
                        if (e.c != 7) e.c = e.c + 1;
                        if (e.u != 3) e.u = e.u + 1;
                    end else begin
                        if (e.c != 0) e.c = 0;
                        else e.v = a;
                        e.u = 0;
                    end
                end else if (bus.fb_alloc_i[p]) begin
                    if (e.u == 0) e = '{a, 3'h0, bus.fb_tag_i[p], 2'h0};
                    else e.u = e.u - 1;
                end
                nm[bus.fb_index_i[p]] = e;
            end
            mdl = nm;
        end
        @(posedge clk_i);
        #1;
        check("coll_cnt", 64'(fb_collision_cnt_o), 64'(exp_cnt));
    endtask

    task automatic fw(input int port, input int idx, input logic [7:0] tag);
        bus.fw_valid_i[port] = 1'b1;
        bus.fw_index_i[port] = 8'(idx);
        bus.fw_tag_i[port]   = tag;
    endtask

    task automatic fb(input int port, input int idx, input logic [7:0] tag,
                      input logic [31:0] act, input logic hit, input logic alloc);
        bus.fb_valid_i[port]  = 1'b1;
        bus.fb_index_i[port]  = 8'(idx);
        bus.fb_tag_i[port]    = tag;
        bus.fb_actual_i[port] = act;
        bus.fb_hit_i[port]    = hit;
        bus.fb_alloc_i[port]  = alloc;
    endtask

    always @(negedge clk_i) begin
        for (int i = 0; i < NP; i++) begin
            if (bus.pred_valid_o[i]) begin
                if (sbq.size() == 0) begin
                    check("spurious_pred_valid", 64'(i), 64'hFFFF);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check("pred_port",   64'(i), 64'(e.port));
                    check("pred_value",  64'(bus.pred_value_o[i]), 64'(e.v));
                    check("pred_conf",   64'(bus.pred_conf_o[i]), 64'(e.c));
                    check("pred_tag",    64'(bus.pred_tag_o[i]), 64'(e.t));
                    check("pred_useful", 64'(bus.pred_useful_o[i]), 64'(e.u));
                    check("pred_hit",    64'(bus.pred_hit_o[i]), 64'(e.h));
                end
            end
        end
    end

    initial begin
        int cycles;
        idle();
        clear_model();
        rst_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_init_done", 64'(init_done_o), 64'h0);
        check("rst_pred_valid", 64'(bus.pred_valid_o), 64'h0);
        check("rst_coll_cnt", 64'(fb_collision_cnt_o), 64'h0);

        // Partial sweep with traffic that must be ignored, then reset at init_ptr=100.
        rst_i = 1'b1;
        fw(0, 3, 8'h00);
        fw(1, 4, 8'h00);
        fb(0, 7, 8'h11, 32'h55, 1'b0, 1'b1);
        fb(1, 7, 8'h22, 32'h66, 1'b0, 1'b1);
        repeat (100) @(posedge clk_i);
        #1;
        check("mid_sweep_init_done", 64'(init_done_o), 64'h0);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        check("reset_pred_valid", 64'(bus.pred_valid_o), 64'h0);
        check("reset_init_done", 64'(init_done_o), 64'h0);
        rst_i = 1'b1;
        cycles = 0;
        while (!init_done_o && cycles < 400) begin
            @(posedge clk_i);
            #1;
            cycles++;
            if (cycles == 128) check("init_pred_valid", 64'(bus.pred_valid_o), 64'h0);
        end
        idle();
        check("init_latency", 64'(cycles), 64'd256);
        check("init_coll_cnt", 64'(fb_collision_cnt_o), 64'h0);
        model_run = 1;

        // Every entry reads back zero after the sweep.
        for (int k = 0; k < 8; k++) begin
            idle();
            fw(0, k * 32, 8'h00);
            fw(1, k * 32 + 31, 8'h00);
            step();
        end

        // Allocate index 5, then probe with matching and non-matching tags.
        idle(); fb(0, 5, 8'h3C, 32'h1234, 1'b0, 1'b1); step();
        idle(); fw(0, 5, 8'h3C); fw(1, 5, 8'h3D); step();

        // Confidence saturation, then two mismatches.
        for (int k = 0; k < 8; k++) begin
            idle(); fb(0, 5, 8'h3C, 32'h1234, 1'b1, 1'b0); fw(1, 5, 8'h3C); step();
        end
        idle(); fb(1, 5, 8'h3C, 32'h0001, 1'b1, 1'b0); step();
        idle(); fw(0, 5, 8'h3C); step();
        idle(); fb(0, 5, 8'h3C, 32'hBEEF, 1'b1, 1'b0); step();
        idle(); fw(0, 5, 8'h3C); fw(1, 6, 8'h00); step();

        // Same-index collision: port 1 wins.
        idle();
        fb(0, 9, 8'h11, 32'hAAAA, 1'b0, 1'b1);
        fb(1, 9, 8'h22, 32'hBBBB, 1'b0, 1'b1);
        step();
        check("coll_cnt_one", 64'(fb_collision_cnt_o), 64'd1);
        idle(); fw(0, 9, 8'h22); step();

        // Predict and update the same entry in one cycle, then read again.
        idle(); fw(0, 9, 8'h22); fb(1, 9, 8'h22, 32'hBBBB, 1'b1, 1'b0); step();
        idle(); fw(1, 9, 8'h22); step();

        // Randomized traffic over a small index window to force interactions.
        for (int k = 0; k < 500; k++) begin
            idle();
            for (int p = 0; p < NP; p++) begin
                if ($urandom_range(0, 3) != 0)
                    fw(p, $urandom_range(0, 7), 8'(8'h10 + $urandom_range(0, 2)));
                if ($urandom_range(0, 2) != 0)
                    fb(p, $urandom_range(0, 7), 8'(8'h10 + $urandom_range(0, 2)),
                       32'($urandom_range(1, 3)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)));
            end
            step();
        end

        idle();
        step();
        step();
        check("sb_drain", 64'(sbq.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
